// File: rtl/excp_commit_ctrl.sv
// ---------------------------------------------------------------------------
// excp_commit_ctrl
//   Writeback-side exception/interrupt commit controller. It accepts the
//   instruction leaving WB, decides whether it commits as an interrupt, an
//   exception, an ERET, an MTC0 or a plain instruction, and emits one-cycle
//   commit pulses to cp0. On an exception, interrupt or ERET it flushes the
//   pipeline and then offers fetch a redirect PC over a valid/ready handshake.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   ws_valid / ws_ready           WB instruction handshake
//   ws_pc, ws_bd, ws_ex,
//   ws_excode, ws_badvaddr        WB instruction and its exception info
//   ws_eret, ws_mtc0,
//   ws_cp0_addr, ws_cp0_wdata     ERET / MTC0 decode and MTC0 operands
//   cp0_status_*, cp0_cause_ip,
//   cp0_epc                       current CP0 state
//   cp0_excp_valid, cp0_excode,
//   cp0_pc, cp0_bd, cp0_badvaddr  exception commit pulse and payload
//   cp0_eret                      ERET commit pulse
//   cp0_mtc0_we, cp0_addr,
//   cp0_wdata                     MTC0 write pulse and payload
//   pipe_flush                    one-cycle flush of all pipeline stages
//   redirect_valid/ready, _pc     redirect handshake towards fetch
// ---------------------------------------------------------------------------
module excp_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter logic [4:0]  INT_EXCODE = 5'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_eret,
    input  logic        ws_mtc0,
    input  logic [7:0]  ws_cp0_addr,
    input  logic [31:0] ws_cp0_wdata,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_status_im,
    input  logic [7:0]  cp0_cause_ip,
    input  logic [31:0] cp0_epc,
    output logic        cp0_excp_valid,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_eret,
    output logic        cp0_mtc0_we,
    output logic [7:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        pipe_flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    localparam logic [7:0] ADDR_STATUS = 8'h60;
    localparam logic [7:0] ADDR_CAUSE  = 8'h68;

    typedef enum logic [1:0] {StIdle, StFlush, StRedirect, StSettle} state_e;

    state_e state;

    logic accept;
    logic int_take;
    logic excp_take;
    logic eret_take;
    logic mtc0_take;
    logic mtc0_settle;
    logic addr_fault;

    // Gated with resetn so ws_ready reads 0 while reset is held.
    assign ws_ready  = (state == StIdle) & resetn;
    assign accept    = ws_valid & (state == StIdle);

    // Interrupts are only taken on an accepted instruction, keeping them precise.
    assign int_take  = cp0_status_ie & ~cp0_status_exl & (|(cp0_cause_ip & cp0_status_im));
    assign excp_take = accept & (int_take | ws_ex);
    assign eret_take = accept & ~int_take & ~ws_ex & ws_eret;
    assign mtc0_take = accept & ~int_take & ~ws_ex & ~ws_eret & ws_mtc0;

    // Writes to Status/Cause need one bubble so the next int_take sees them.
    assign mtc0_settle = mtc0_take &
                         ((ws_cp0_addr == ADDR_STATUS) | (ws_cp0_addr == ADDR_CAUSE));

    // Only AdEL (4) and AdES (5) carry a faulting address.
    assign addr_fault = ~int_take & ((ws_excode == 5'd4) | (ws_excode == 5'd5));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= StIdle;
            cp0_excp_valid <= 1'b0;
            cp0_excode     <= 5'd0;
            cp0_pc         <= 32'd0;
            cp0_bd         <= 1'b0;
            cp0_badvaddr   <= 32'd0;
            cp0_eret       <= 1'b0;
            cp0_mtc0_we    <= 1'b0;
            cp0_addr       <= 8'd0;
            cp0_wdata      <= 32'd0;
            pipe_flush     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            // Commit strobes are single-cycle by default.
            cp0_excp_valid <= 1'b0;
            cp0_eret       <= 1'b0;
            cp0_mtc0_we    <= 1'b0;
            pipe_flush     <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (excp_take) begin
                        cp0_excp_valid <= 1'b1;
                        cp0_excode     <= int_take ? INT_EXCODE : ws_excode;
                        cp0_pc         <= ws_pc;
                        cp0_bd         <= ws_bd;
                        cp0_badvaddr   <= addr_fault ? ws_badvaddr : 32'd0;
                        redirect_pc    <= EXC_VECTOR;
                        pipe_flush     <= 1'b1;
                        state          <= StFlush;
                    end else if (eret_take) begin
                        cp0_eret       <= 1'b1;
                        redirect_pc    <= cp0_epc;
                        pipe_flush     <= 1'b1;
                        state          <= StFlush;
                    end else if (mtc0_take) begin
                        cp0_mtc0_we    <= 1'b1;
                        cp0_addr       <= ws_cp0_addr;
                        cp0_wdata      <= ws_cp0_wdata;
                        if (mtc0_settle) begin
                            state <= StSettle;
                        end
                    end
                end
                StFlush: begin
                    redirect_valid <= 1'b1;
                    state          <= StRedirect;
                end
                StRedirect: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= StIdle;
                    end
                end
                StSettle: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Bench for excp_commit_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of the visible outputs.
`timescale 1ns/1ps
module tb_excp_commit_ctrl;

    localparam logic [31:0] VEC = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid, ws_ready, ws_bd, ws_ex, ws_eret, ws_mtc0;
    logic [31:0] ws_pc, ws_badvaddr, ws_cp0_wdata, cp0_epc;
    logic [4:0]  ws_excode;
    logic [7:0]  ws_cp0_addr, cp0_status_im, cp0_cause_ip;
    logic        cp0_status_ie, cp0_status_exl;
    logic        cp0_excp_valid, cp0_bd, cp0_eret, cp0_mtc0_we, pipe_flush;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_pc, cp0_badvaddr, cp0_wdata, redirect_pc;
    logic [7:0]  cp0_addr;
    logic        redirect_valid, redirect_ready;

    always #5 clk = ~clk;

    excp_commit_ctrl dut (
        .clk(clk), .resetn(resetn),
        .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_bd(ws_bd),
        .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_badvaddr(ws_badvaddr),
        .ws_eret(ws_eret), .ws_mtc0(ws_mtc0), .ws_cp0_addr(ws_cp0_addr),
        .ws_cp0_wdata(ws_cp0_wdata), .cp0_status_ie(cp0_status_ie),
        .cp0_status_exl(cp0_status_exl), .cp0_status_im(cp0_status_im),
        .cp0_cause_ip(cp0_cause_ip), .cp0_epc(cp0_epc),
        .cp0_excp_valid(cp0_excp_valid), .cp0_excode(cp0_excode), .cp0_pc(cp0_pc),
        .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr), .cp0_eret(cp0_eret),
        .cp0_mtc0_we(cp0_mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of what should be visible on the outputs in the current cycle.
    bit          m_flush, m_rv, m_stall, m_excp, m_eret, m_we;
    logic [31:0] m_rpc, m_pc, m_bad, m_wdata;
    logic [4:0]  m_excode;
    logic        m_bd;
    logic [7:0]  m_addr;

    function automatic bit m_ready();
        return !(m_flush || m_rv || m_stall);
    endfunction

    task automatic model_reset();
        m_flush = 0; m_rv = 0; m_stall = 0; m_excp = 0; m_eret = 0; m_we = 0;
    endtask

    task automatic compare();
        check("ws_ready", ws_ready, m_ready());
        check("excp_valid", cp0_excp_valid, m_excp);
        check("eret", cp0_eret, m_eret);
        check("mtc0_we", cp0_mtc0_we, m_we);
        check("pipe_flush", pipe_flush, m_flush);
        check("redirect_valid", redirect_valid, m_rv);
        if (m_excp) begin
            check("excode", cp0_excode, m_excode);
            check("pc", cp0_pc, m_pc);
            check("bd", cp0_bd, m_bd);
            check("badvaddr", cp0_badvaddr, m_bad);
        end
        if (m_we) begin
            check("mtc0_addr", cp0_addr, m_addr);
            check("mtc0_wdata", cp0_wdata, m_wdata);
        end
        if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
    endtask

    // Advance one clock with the currently driven inputs and check the result.
    task automatic cycle();
        bit acc, it, n_flush, n_rv, n_stall, n_excp, n_eret, n_we;
        acc = ws_valid && m_ready();
        it  = cp0_status_ie && !cp0_status_exl && ((cp0_cause_ip & cp0_status_im) != 8'd0);
        n_flush = 0; n_stall = 0; n_excp = 0; n_eret = 0; n_we = 0;
        n_rv = m_rv;
        if (m_rv && redirect_ready) n_rv = 0;
        if (m_flush) n_rv = 1;
        if (acc) begin
            if (it || ws_ex) begin
                n_excp   = 1;
                m_excode = it ? 5'd0 : ws_excode;
                m_pc     = ws_pc;
                m_bd     = ws_bd;
                m_bad    = (!it && (ws_excode == 5'd4 || ws_excode == 5'd5)) ? ws_badvaddr : 32'd0;
                m_rpc    = VEC;
                n_flush  = 1;
            end else if (ws_eret) begin
                n_eret  = 1;
                m_rpc   = cp0_epc;
                n_flush = 1;
            end else if (ws_mtc0) begin
                n_we    = 1;
                m_addr  = ws_cp0_addr;
                m_wdata = ws_cp0_wdata;
                n_stall = (ws_cp0_addr == 8'h60) || (ws_cp0_addr == 8'h68);
            end
        end
        @(posedge clk);
        #1;
        m_flush = n_flush; m_rv = n_rv; m_stall = n_stall;
        m_excp = n_excp; m_eret = n_eret; m_we = n_we;
        compare();
    endtask

    task automatic clear_inputs();
        ws_valid = 0; ws_pc = 0; ws_bd = 0; ws_ex = 0; ws_excode = 0; ws_badvaddr = 0;
        ws_eret = 0; ws_mtc0 = 0; ws_cp0_addr = 0; ws_cp0_wdata = 0;
        cp0_status_ie = 0; cp0_status_exl = 0; cp0_status_im = 0; cp0_cause_ip = 0;
        cp0_epc = 0; redirect_ready = 0;
    endtask

    task automatic drain();
        clear_inputs();
        redirect_ready = 1;
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic rand_inputs();
        ws_valid       = ($urandom_range(0, 3) != 0);
        ws_pc          = $urandom & 32'hffff_fffc;
        ws_bd          = $urandom_range(0, 1);
        ws_ex          = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
            0: ws_excode = 5'd4;
            1: ws_excode = 5'd5;
            2: ws_excode = 5'd8;
            default: ws_excode = 5'($urandom);
        endcase
        ws_badvaddr    = $urandom;
        ws_eret        = ($urandom_range(0, 5) == 0);
        ws_mtc0        = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 3))
            0: ws_cp0_addr = 8'h60;
            1: ws_cp0_addr = 8'h68;
            2: ws_cp0_addr = 8'h58;
            default: ws_cp0_addr = 8'($urandom);
        endcase
        ws_cp0_wdata   = $urandom;
        cp0_status_ie  = $urandom_range(0, 1);
        cp0_status_exl = $urandom_range(0, 1);
        cp0_status_im  = 8'($urandom);
        cp0_cause_ip   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
        cp0_epc        = $urandom;
        redirect_ready = $urandom_range(0, 1);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        resetn = 0;
        #3;
        check("rst_ws_ready", ws_ready, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_excp_valid", cp0_excp_valid, 0);
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        compare();

        // Exception, excode 8.
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd8; ws_pc = 32'hbfc00100;
        cycle();
        drain();

        // AdEL in a delay slot, then excode 8 with a stray badvaddr.
        clear_inputs();
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd4; ws_bd = 1; ws_badvaddr = 32'h00001001;
        ws_pc = 32'h80000010;
        cycle();
        drain();
        clear_inputs();
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd8; ws_badvaddr = 32'h00001001;
        cycle();
        drain();

        // ERET with fetch stalling the redirect for 3 cycles.
        clear_inputs();
        ws_valid = 1; ws_eret = 1; cp0_epc = 32'hbfc00200;
        cycle();
        clear_inputs();
        ws_valid = 1;
        cycle();
        for (int k = 0; k < 3; k++) cycle();
        redirect_ready = 1;
        cycle();
        clear_inputs();
        cycle();

        // Interrupt wins over an exception; EXL masks it.
        clear_inputs();
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd8; ws_pc = 32'hbfc00300;
        cp0_status_ie = 1; cp0_status_im = 8'h80; cp0_cause_ip = 8'h80;
        cycle();
        drain();
        clear_inputs();
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd8;
        cp0_status_ie = 1; cp0_status_exl = 1; cp0_status_im = 8'h80; cp0_cause_ip = 8'h80;
        cycle();
        drain();

        // MTC0 to Status stalls one cycle; MTC0 elsewhere streams.
        clear_inputs();
        ws_valid = 1; ws_mtc0 = 1; ws_cp0_addr = 8'h60; ws_cp0_wdata = 32'h0000ff01;
        cycle();
        cycle();
        ws_cp0_addr = 8'h58; ws_cp0_wdata = 32'h12345678;
        cycle();
        ws_cp0_wdata = 32'h9abcdef0;
        cycle();
        clear_inputs();
        cycle();

        // Asynchronous reset while a redirect is pending.
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd10;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        #2;
        resetn = 0;
        #1;
        check("arst_redirect_valid", redirect_valid, 0);
        check("arst_ws_ready", ws_ready, 0);
        check("arst_pipe_flush", pipe_flush, 0);
        check("arst_excp_valid", cp0_excp_valid, 0);
        check("arst_redirect_pc", redirect_pc, 0);
        model_reset();
        @(negedge clk);
        resetn = 1;
        #1;
        check("arst_release_ready", ws_ready, 1);
        @(posedge clk);
        #1;
        compare();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
